// File: rtl/arm_code_emitter.sv
// Two-stage template emitter: stage A registers the id for the template ROM, stage B
// classifies the ROM word, patches BL offsets and holds the code-memory write request.
module arm_code_emitter #(
   parameter int unsigned ADDR_W  = 16,
   parameter logic [6:0]  CALL_ID = 7'h2C
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              id_valid,
   output logic              id_ready,
   input  logic [6:0]        id_data,
   input  logic              id_last,
   input  logic [ADDR_W-1:0] id_target,
   output logic [6:0]        rom_id,
   input  logic [31:0]       rom_word,
   output logic              mem_valid,
   input  logic              mem_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [ADDR_W-1:0] emit_count
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, ERR} state_t;

   state_t            state, state_nx;
   logic [ADDR_W-1:0] pc, pc_nx, emit_count_nx, a_target, a_target_nx, mem_addr_nx;
   logic              a_valid, a_valid_nx, a_last, a_last_nx;
   logic              mem_valid_nx, error_nx, done_nx;
   logic [6:0]        rom_id_nx;
   logic [31:0]       mem_wdata_nx;
   logic              a_adv, id_fire, mem_fire, unmapped, empty_tpl;
   logic [ADDR_W-1:0] rel;
   logic [23:0]       off;

   assign a_adv     = a_valid && (!mem_valid || mem_ready);
   assign id_ready  = (state == RUN) && (!a_valid || a_adv);
   assign id_fire   = id_valid && id_ready;
   assign mem_fire  = mem_valid && mem_ready;
   assign busy      = (state != IDLE);
   assign unmapped  = (rom_word == '1);
   assign empty_tpl = (rom_id == '0);
   // ARM reads PC as the current word + 2 words
   assign rel       = a_target - pc - ADDR_W'(2);
   assign off       = 24'($signed(rel));

   // pc names the address the next stage-B word will take, so it steps when a word
   // enters stage B; this equals "pc+1 per handshake" without a same-cycle collision.
   always_comb begin
      state_nx      = state;
      pc_nx         = pc;
      emit_count_nx = emit_count;
      a_valid_nx    = a_valid;
      rom_id_nx     = rom_id;
      a_last_nx     = a_last;
      a_target_nx   = a_target;
      mem_valid_nx  = mem_valid;
      mem_addr_nx   = mem_addr;
      mem_wdata_nx  = mem_wdata;
      error_nx      = error;
      done_nx       = 1'b0;

      if (mem_fire) begin
         emit_count_nx = emit_count + ADDR_W'(1);
         mem_valid_nx  = 1'b0;
      end
      if (a_adv) a_valid_nx = 1'b0;
      if (id_fire) begin
         a_valid_nx  = 1'b1;
         rom_id_nx   = id_data;
         a_last_nx   = id_last;
         a_target_nx = id_target;
      end
      if (a_adv && !unmapped && !empty_tpl) begin
         mem_valid_nx = 1'b1;
         mem_addr_nx  = pc;
         pc_nx        = pc + ADDR_W'(1);
         mem_wdata_nx = (rom_id == CALL_ID) ? {rom_word[31:24], off} : rom_word;
      end

      case (state)
         IDLE, ERR: if (start) begin
            state_nx      = RUN;
            pc_nx         = base_addr;
            emit_count_nx = '0;
            error_nx      = 1'b0;
         end
         RUN: if (id_fire && id_last) state_nx = DRAIN;
         DRAIN: if ((!a_valid || (a_adv && a_last)) && !mem_valid_nx) begin
            state_nx = IDLE;
            done_nx  = 1'b1;
         end
         default: state_nx = IDLE;
      endcase

      if ((state == RUN || state == DRAIN) && a_adv && unmapped) begin
         state_nx     = ERR;
         error_nx     = 1'b1;
         a_valid_nx   = 1'b0;
         mem_valid_nx = 1'b0;
         done_nx      = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         pc         <= '0;
         emit_count <= '0;
         a_valid    <= 1'b0;
         rom_id     <= '0;
         a_last     <= 1'b0;
         a_target   <= '0;
         mem_valid  <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         error      <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= state_nx;
         pc         <= pc_nx;
         emit_count <= emit_count_nx;
         a_valid    <= a_valid_nx;
         rom_id     <= rom_id_nx;
         a_last     <= a_last_nx;
         a_target   <= a_target_nx;
         mem_valid  <= mem_valid_nx;
         mem_addr   <= mem_addr_nx;
         mem_wdata  <= mem_wdata_nx;
         error      <= error_nx;
         done       <= done_nx;
      end
   end

endmodule
